// File: rtl/axi_arbiter.sv
// Arbitrates IFU fetches and LSU loads/stores onto one AXI4 master, one transaction at a time.
// Define AXI_ARBITER_RR_EN for round-robin arbitration; default is fixed priority (LSU wins).
module axi_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    // IFU
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_req_addr,
    output logic                ifu_rsp_valid,
    output logic [DATA_W-1:0]   ifu_rsp_data,
    output logic                ifu_rsp_err,
    // LSU
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic                lsu_req_we,
    input  logic [ADDR_W-1:0]   lsu_req_addr,
    input  logic [DATA_W-1:0]   lsu_req_wdata,
    input  logic [DATA_W/8-1:0] lsu_req_wstrb,
    input  logic [2:0]          lsu_req_size,
    output logic                lsu_rsp_valid,
    output logic [DATA_W-1:0]   lsu_rsp_rdata,
    output logic                lsu_rsp_err,
    // AXI4 master
    input  logic                io_master_awready,
    output logic                io_master_awvalid,
    output logic [ADDR_W-1:0]   io_master_awaddr,
    output logic [3:0]          io_master_awid,
    output logic [7:0]          io_master_awlen,
    output logic [2:0]          io_master_awsize,
    output logic [1:0]          io_master_awburst,
    input  logic                io_master_wready,
    output logic                io_master_wvalid,
    output logic [DATA_W-1:0]   io_master_wdata,
    output logic [DATA_W/8-1:0] io_master_wstrb,
    output logic                io_master_wlast,
    output logic                io_master_bready,
    input  logic                io_master_bvalid,
    input  logic [1:0]          io_master_bresp,
    input  logic [3:0]          io_master_bid,
    input  logic                io_master_arready,
    output logic                io_master_arvalid,
    output logic [ADDR_W-1:0]   io_master_araddr,
    output logic [3:0]          io_master_arid,
    output logic [7:0]          io_master_arlen,
    output logic [2:0]          io_master_arsize,
    output logic [1:0]          io_master_arburst,
    output logic                io_master_rready,
    input  logic                io_master_rvalid,
    input  logic [1:0]          io_master_rresp,
    input  logic [DATA_W-1:0]   io_master_rdata,
    input  logic                io_master_rlast,
    input  logic [3:0]          io_master_rid
);
    typedef enum logic [2:0] {S_IDLE, S_IF_AR, S_IF_R, S_LS_AR, S_LS_R, S_LS_W, S_LS_B} state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic [2:0]          size_q;
    logic                id_q;
    logic                arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
    logic                ifu_rsp_valid_q, ifu_rsp_err_q, lsu_rsp_valid_q, lsu_rsp_err_q;
    logic [DATA_W-1:0]   ifu_rsp_data_q, lsu_rsp_rdata_q;
    logic                grant_ifu, grant_lsu, idle;
    logic                unused_ok;

    // Single-beat transfers: IDs and last flags from the slave carry no information.
    assign unused_ok = ^{io_master_rid, io_master_bid, io_master_rlast};

`ifdef AXI_ARBITER_RR_EN
    logic last_lsu_q;
    assign grant_lsu = lsu_req_valid && (!ifu_req_valid || !last_lsu_q);

    always_ff @(posedge clk_i) begin
        if (rst_i)              last_lsu_q <= 1'b0;
        else if (lsu_req_ready) last_lsu_q <= 1'b1;
        else if (ifu_req_ready) last_lsu_q <= 1'b0;
    end
`else
    assign grant_lsu = lsu_req_valid;
`endif
    assign grant_ifu = ifu_req_valid && !grant_lsu;

    // Request ready is a combinational grant so payload is latched in the handshake cycle.
    assign idle          = (state_q == S_IDLE) && !rst_i;
    assign ifu_req_ready = idle && grant_ifu;
    assign lsu_req_ready = idle && grant_lsu;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= S_IDLE;
            addr_q          <= '0;
            wdata_q         <= '0;
            wstrb_q         <= '0;
            size_q          <= 3'd0;
            id_q            <= 1'b0;
            arvalid_q       <= 1'b0;
            rready_q        <= 1'b0;
            awvalid_q       <= 1'b0;
            wvalid_q        <= 1'b0;
            bready_q        <= 1'b0;
            ifu_rsp_valid_q <= 1'b0;
            ifu_rsp_err_q   <= 1'b0;
            ifu_rsp_data_q  <= '0;
            lsu_rsp_valid_q <= 1'b0;
            lsu_rsp_err_q   <= 1'b0;
            lsu_rsp_rdata_q <= '0;
        end else begin
            ifu_rsp_valid_q <= 1'b0;
            lsu_rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (lsu_req_ready) begin
                        addr_q  <= lsu_req_addr;
                        wdata_q <= lsu_req_wdata;
                        wstrb_q <= lsu_req_wstrb;
                        size_q  <= lsu_req_size;
                        id_q    <= 1'b1;
                        if (lsu_req_we) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= S_LS_W;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= S_LS_AR;
                        end
                    end else if (ifu_req_ready) begin
                        addr_q    <= ifu_req_addr;
                        size_q    <= 3'b010;
                        id_q      <= 1'b0;
                        arvalid_q <= 1'b1;
                        state_q   <= S_IF_AR;
                    end
                end
                S_IF_AR, S_LS_AR: begin
                    if (io_master_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= (state_q == S_IF_AR) ? S_IF_R : S_LS_R;
                    end
                end
                S_IF_R: begin
                    if (io_master_rvalid) begin
                        rready_q        <= 1'b0;
                        ifu_rsp_valid_q <= 1'b1;
                        ifu_rsp_data_q  <= io_master_rdata;
                        ifu_rsp_err_q   <= |io_master_rresp;
                        state_q         <= S_IDLE;
                    end
                end
                S_LS_R: begin
                    if (io_master_rvalid) begin
                        rready_q        <= 1'b0;
                        lsu_rsp_valid_q <= 1'b1;
                        lsu_rsp_rdata_q <= io_master_rdata;
                        lsu_rsp_err_q   <= |io_master_rresp;
                        state_q         <= S_IDLE;
                    end
                end
                S_LS_W: begin
                    // AW and W complete independently; leave once neither is pending.
                    if (io_master_awready) awvalid_q <= 1'b0;
                    if (io_master_wready)  wvalid_q  <= 1'b0;
                    if ((!awvalid_q || io_master_awready) && (!wvalid_q || io_master_wready)) begin
                        bready_q <= 1'b1;
                        state_q  <= S_LS_B;
                    end
                end
                S_LS_B: begin
                    if (io_master_bvalid) begin
                        bready_q        <= 1'b0;
                        lsu_rsp_valid_q <= 1'b1;
                        lsu_rsp_rdata_q <= '0;
                        lsu_rsp_err_q   <= |io_master_bresp;
                        state_q         <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign io_master_awvalid = awvalid_q;
    assign io_master_awaddr  = addr_q;
    assign io_master_awid    = 4'd1;
    assign io_master_awlen   = 8'd0;
    assign io_master_awsize  = size_q;
    assign io_master_awburst = 2'b01;
    assign io_master_wvalid  = wvalid_q;
    assign io_master_wdata   = wdata_q;
    assign io_master_wstrb   = wstrb_q;
    assign io_master_wlast   = 1'b1;
    assign io_master_bready  = bready_q;
    assign io_master_arvalid = arvalid_q;
    assign io_master_araddr  = addr_q;
    assign io_master_arid    = {3'b000, id_q};
    assign io_master_arlen   = 8'd0;
    assign io_master_arsize  = size_q;
    assign io_master_arburst = 2'b01;
    assign io_master_rready  = rready_q;

    assign ifu_rsp_valid = ifu_rsp_valid_q;
    assign ifu_rsp_data  = ifu_rsp_data_q;
    assign ifu_rsp_err   = ifu_rsp_err_q;
    assign lsu_rsp_valid = lsu_rsp_valid_q;
    assign lsu_rsp_rdata = lsu_rsp_rdata_q;
    assign lsu_rsp_err   = lsu_rsp_err_q;
endmodule

// File: tb/tb_axi_arbiter.sv
// Directed bench for axi_arbiter: drives the AXI slave side by hand, checks on the falling edge.
module tb_axi_arbiter;
    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        ifu_req_valid = 1'b0, ifu_req_ready;
    logic [31:0] ifu_req_addr = '0;
    logic        ifu_rsp_valid, ifu_rsp_err;
    logic [31:0] ifu_rsp_data;
    logic        lsu_req_valid = 1'b0, lsu_req_ready, lsu_req_we = 1'b0;
    logic [31:0] lsu_req_addr = '0, lsu_req_wdata = '0;
    logic [3:0]  lsu_req_wstrb = '0;
    logic [2:0]  lsu_req_size = '0;
    logic        lsu_rsp_valid, lsu_rsp_err;
    logic [31:0] lsu_rsp_rdata;
    logic        awready = 1'b0, awvalid, wready = 1'b0, wvalid, wlast, bready, bvalid = 1'b0;
    logic [31:0] awaddr, wdata, araddr;
    logic [3:0]  awid, wstrb, arid;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp = 2'b00, rresp = 2'b00;
    logic        arready = 1'b0, arvalid, rready, rvalid = 1'b0;
    logic [31:0] rdata = '0;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    axi_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data), .ifu_rsp_err(ifu_rsp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_we(lsu_req_we),
        .lsu_req_addr(lsu_req_addr), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wstrb(lsu_req_wstrb),
        .lsu_req_size(lsu_req_size), .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_rdata(lsu_rsp_rdata),
        .lsu_rsp_err(lsu_rsp_err),
        .io_master_awready(awready), .io_master_awvalid(awvalid), .io_master_awaddr(awaddr),
        .io_master_awid(awid), .io_master_awlen(awlen), .io_master_awsize(awsize),
        .io_master_awburst(awburst), .io_master_wready(wready), .io_master_wvalid(wvalid),
        .io_master_wdata(wdata), .io_master_wstrb(wstrb), .io_master_wlast(wlast),
        .io_master_bready(bready), .io_master_bvalid(bvalid), .io_master_bresp(bresp),
        .io_master_bid(4'd1), .io_master_arready(arready), .io_master_arvalid(arvalid),
        .io_master_araddr(araddr), .io_master_arid(arid), .io_master_arlen(arlen),
        .io_master_arsize(arsize), .io_master_arburst(arburst), .io_master_rready(rready),
        .io_master_rvalid(rvalid), .io_master_rresp(rresp), .io_master_rdata(rdata),
        .io_master_rlast(1'b1), .io_master_rid(4'd0)
    );

    task automatic test_reset();
        rst_i = 1'b1; ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total++; if ({ifu_req_ready, lsu_req_ready} !== 2'b00) begin
            bad++; $display("FAIL reset_req_ready got=%b exp=00", {ifu_req_ready, lsu_req_ready}); end
        total++; if ({arvalid, awvalid, wvalid, rready, bready} !== 5'b0) begin
            bad++; $display("FAIL reset_axi got=%b exp=00000", {arvalid, awvalid, wvalid, rready, bready}); end
        total++; if ({ifu_rsp_valid, ifu_rsp_err, lsu_rsp_valid, lsu_rsp_err} !== 4'b0) begin
            bad++; $display("FAIL reset_rsp got=%b exp=0000", {ifu_rsp_valid, ifu_rsp_err, lsu_rsp_valid, lsu_rsp_err}); end
        total++; if ({ifu_rsp_data, lsu_rsp_rdata} !== 64'h0) begin
            bad++; $display("FAIL reset_rsp_data got=%h exp=0", {ifu_rsp_data, lsu_rsp_rdata}); end
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        @(negedge clk); rst_i = 1'b0;
    endtask

    task automatic test_ifu_read();
        @(negedge clk); ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0000; #1;
        total++; if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
            bad++; $display("FAIL ifu_grant got=%b exp=10", {ifu_req_ready, lsu_req_ready}); end
        @(negedge clk); ifu_req_valid = 1'b0;
        total++; if ({arvalid, araddr, arid, arlen, arsize, arburst} !== {1'b1, 32'h8000_0000, 4'd0, 8'd0, 3'd2, 2'b01}) begin
            bad++; $display("FAIL ifu_ar got=%h exp=%h", {arvalid, araddr, arid, arlen, arsize, arburst},
                            {1'b1, 32'h8000_0000, 4'd0, 8'd0, 3'd2, 2'b01}); end
        @(negedge clk);
        total++; if (arvalid !== 1'b1) begin bad++; $display("FAIL ifu_ar_hold got=%b exp=1", arvalid); end
        arready = 1'b1;
        @(negedge clk); arready = 1'b0;
        total++; if ({arvalid, rready} !== 2'b01) begin
            bad++; $display("FAIL ifu_r_phase got=%b exp=01", {arvalid, rready}); end
        rvalid = 1'b1; rdata = 32'h0000_0413; rresp = 2'b00;
        @(negedge clk); rvalid = 1'b0;
        total++; if ({ifu_rsp_valid, ifu_rsp_data, ifu_rsp_err, lsu_rsp_valid, rready} !== {1'b1, 32'h0000_0413, 3'b000}) begin
            bad++; $display("FAIL ifu_rsp got=%h exp=%h", {ifu_rsp_valid, ifu_rsp_data, ifu_rsp_err, lsu_rsp_valid, rready},
                            {1'b1, 32'h0000_0413, 3'b000}); end
        @(negedge clk);
        total++; if (ifu_rsp_valid !== 1'b0) begin bad++; $display("FAIL ifu_rsp_pulse got=%b exp=0", ifu_rsp_valid); end
    endtask

    task automatic test_lsu_store();
        @(negedge clk);
        lsu_req_valid = 1'b1; lsu_req_we = 1'b1; lsu_req_addr = 32'h8000_1000;
        lsu_req_wdata = 32'hDEAD_BEEF; lsu_req_wstrb = 4'hF; lsu_req_size = 3'd2; #1;
        total++; if ({lsu_req_ready, ifu_req_ready} !== 2'b10) begin
            bad++; $display("FAIL st_grant got=%b exp=10", {lsu_req_ready, ifu_req_ready}); end
        @(negedge clk); lsu_req_valid = 1'b0;
        total++; if ({awvalid, wvalid, awaddr, awid, awlen, awsize, awburst, wdata, wstrb, wlast, arvalid} !==
                     {2'b11, 32'h8000_1000, 4'd1, 8'd0, 3'd2, 2'b01, 32'hDEAD_BEEF, 4'hF, 2'b10}) begin
            bad++; $display("FAIL st_aw_w got=%h exp=%h", {awvalid, wvalid, awaddr, awid, awlen, awsize, awburst, wdata, wstrb, wlast, arvalid},
                            {2'b11, 32'h8000_1000, 4'd1, 8'd0, 3'd2, 2'b01, 32'hDEAD_BEEF, 4'hF, 2'b10}); end
        awready = 1'b1;
        @(negedge clk); awready = 1'b0;
        total++; if ({awvalid, wvalid, bready} !== 3'b010) begin
            bad++; $display("FAIL st_aw_done got=%b exp=010", {awvalid, wvalid, bready}); end
        @(negedge clk);
        total++; if ({wvalid, wdata} !== {1'b1, 32'hDEAD_BEEF}) begin
            bad++; $display("FAIL st_w_hold got=%h exp=%h", {wvalid, wdata}, {1'b1, 32'hDEAD_BEEF}); end
        @(negedge clk); wready = 1'b1;
        @(negedge clk); wready = 1'b0;
        total++; if ({wvalid, bready} !== 2'b01) begin
            bad++; $display("FAIL st_b_phase got=%b exp=01", {wvalid, bready}); end
        bvalid = 1'b1; bresp = 2'b00;
        @(negedge clk); bvalid = 1'b0;
        total++; if ({lsu_rsp_valid, lsu_rsp_err, lsu_rsp_rdata, bready, ifu_rsp_valid} !== {2'b10, 32'h0, 2'b00}) begin
            bad++; $display("FAIL st_rsp got=%h exp=%h", {lsu_rsp_valid, lsu_rsp_err, lsu_rsp_rdata, bready, ifu_rsp_valid},
                            {2'b10, 32'h0, 2'b00}); end
    endtask

    task automatic test_store_w_first();
        @(negedge clk);
        lsu_req_valid = 1'b1; lsu_req_we = 1'b1; lsu_req_addr = 32'h8000_2000;
        lsu_req_wdata = 32'h1122_3344; lsu_req_wstrb = 4'h3; lsu_req_size = 3'd1; #1;
        total++; if (lsu_req_ready !== 1'b1) begin bad++; $display("FAIL wf_grant got=%b exp=1", lsu_req_ready); end
        @(negedge clk); lsu_req_valid = 1'b0;
        total++; if ({awvalid, wvalid, awsize, wstrb} !== {2'b11, 3'd1, 4'h3}) begin
            bad++; $display("FAIL wf_aw_w got=%h exp=%h", {awvalid, wvalid, awsize, wstrb}, {2'b11, 3'd1, 4'h3}); end
        wready = 1'b1;
        @(negedge clk); wready = 1'b0;
        total++; if ({awvalid, wvalid, bready} !== 3'b100) begin
            bad++; $display("FAIL wf_w_done got=%b exp=100", {awvalid, wvalid, bready}); end
        awready = 1'b1;
        @(negedge clk); awready = 1'b0;
        total++; if ({awvalid, bready} !== 2'b01) begin
            bad++; $display("FAIL wf_b_phase got=%b exp=01", {awvalid, bready}); end
        bvalid = 1'b1; bresp = 2'b10;
        @(negedge clk); bvalid = 1'b0; bresp = 2'b00;
        total++; if ({lsu_rsp_valid, lsu_rsp_err} !== 2'b11) begin
            bad++; $display("FAIL wf_rsp_err got=%b exp=11", {lsu_rsp_valid, lsu_rsp_err}); end
    endtask

    task automatic test_lsu_load_err();
        @(negedge clk);
        lsu_req_valid = 1'b1; lsu_req_we = 1'b0; lsu_req_addr = 32'h8000_3000; lsu_req_size = 3'd0; #1;
        total++; if (lsu_req_ready !== 1'b1) begin bad++; $display("FAIL ld_grant got=%b exp=1", lsu_req_ready); end
        @(negedge clk); lsu_req_valid = 1'b0;
        total++; if ({arvalid, arid, araddr, arsize, awvalid} !== {1'b1, 4'd1, 32'h8000_3000, 3'd0, 1'b0}) begin
            bad++; $display("FAIL ld_ar got=%h exp=%h", {arvalid, arid, araddr, arsize, awvalid}, {1'b1, 4'd1, 32'h8000_3000, 3'd0, 1'b0}); end
        arready = 1'b1;
        @(negedge clk); arready = 1'b0;
        total++; if (rready !== 1'b1) begin bad++; $display("FAIL ld_rready got=%b exp=1", rready); end
        rvalid = 1'b1; rdata = 32'hCAFE_F00D; rresp = 2'b10;
        @(negedge clk); rvalid = 1'b0; rresp = 2'b00;
        total++; if ({lsu_rsp_valid, lsu_rsp_err, lsu_rsp_rdata, ifu_rsp_valid} !== {2'b11, 32'hCAFE_F00D, 1'b0}) begin
            bad++; $display("FAIL ld_rsp got=%h exp=%h", {lsu_rsp_valid, lsu_rsp_err, lsu_rsp_rdata, ifu_rsp_valid},
                            {2'b11, 32'hCAFE_F00D, 1'b0}); end
        @(negedge clk);
        total++; if ({lsu_rsp_valid, ifu_rsp_valid} !== 2'b00) begin
            bad++; $display("FAIL ld_rsp_pulse got=%b exp=00", {lsu_rsp_valid, ifu_rsp_valid}); end
    endtask

    // Both requesters hold valid across four grants; responses land in the next grant cycle.
    task automatic test_simultaneous();
        logic el;
        @(negedge clk); rst_i = 1'b1;
        @(negedge clk); rst_i = 1'b0;
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0100;
        lsu_req_valid = 1'b1; lsu_req_we = 1'b0; lsu_req_addr = 32'h8000_4000; lsu_req_size = 3'd2; #1;
        for (int k = 0; k < 4; k++) begin
`ifdef AXI_ARBITER_RR_EN
            el = (k % 2 == 0);
`else
            el = 1'b1;
`endif
            total++; if ({lsu_req_ready, ifu_req_ready} !== {el, !el}) begin
                bad++; $display("FAIL sim_grant%0d got=%b exp=%b", k, {lsu_req_ready, ifu_req_ready}, {el, !el}); end
            @(negedge clk);
            total++; if ({arvalid, arid, araddr} !== {1'b1, 3'b000, el, (el ? 32'h8000_4000 : 32'h8000_0100)}) begin
                bad++; $display("FAIL sim_ar%0d got=%h exp=%h", k, {arvalid, arid, araddr},
                                {1'b1, 3'b000, el, (el ? 32'h8000_4000 : 32'h8000_0100)}); end
            arready = 1'b1;
            @(negedge clk); arready = 1'b0; rvalid = 1'b1; rdata = 32'h100 + k; rresp = 2'b00;
            @(negedge clk); rvalid = 1'b0;
            if (k == 3) begin ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; end
            total++; if ({lsu_rsp_valid, ifu_rsp_valid} !== {el, !el}) begin
                bad++; $display("FAIL sim_rsp%0d got=%b exp=%b", k, {lsu_rsp_valid, ifu_rsp_valid}, {el, !el}); end
            #1;
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk); ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0200; #1;
        total++; if (ifu_req_ready !== 1'b1) begin bad++; $display("FAIL rm_grant got=%b exp=1", ifu_req_ready); end
        @(negedge clk); ifu_req_valid = 1'b0; arready = 1'b1;
        @(negedge clk); arready = 1'b0;
        total++; if (rready !== 1'b1) begin bad++; $display("FAIL rm_in_r got=%b exp=1", rready); end
        rst_i = 1'b1;
        @(negedge clk); rst_i = 1'b0;
        total++; if ({rready, arvalid, ifu_rsp_valid, ifu_rsp_data} !== 35'h0) begin
            bad++; $display("FAIL rm_abandon got=%h exp=0", {rready, arvalid, ifu_rsp_valid, ifu_rsp_data}); end
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0300; #1;
        total++; if (ifu_req_ready !== 1'b1) begin bad++; $display("FAIL rm_idle got=%b exp=1", ifu_req_ready); end
        @(negedge clk); ifu_req_valid = 1'b0;
        total++; if ({arvalid, araddr, ifu_rsp_valid} !== {1'b1, 32'h8000_0300, 1'b0}) begin
            bad++; $display("FAIL rm_ar got=%h exp=%h", {arvalid, araddr, ifu_rsp_valid}, {1'b1, 32'h8000_0300, 1'b0}); end
        arready = 1'b1;
        @(negedge clk); arready = 1'b0; rvalid = 1'b1; rdata = 32'h0000_ABCD; rresp = 2'b00;
        @(negedge clk); rvalid = 1'b0;
        total++; if ({ifu_rsp_valid, ifu_rsp_data, ifu_rsp_err} !== {1'b1, 32'h0000_ABCD, 1'b0}) begin
            bad++; $display("FAIL rm_rsp got=%h exp=%h", {ifu_rsp_valid, ifu_rsp_data, ifu_rsp_err}, {1'b1, 32'h0000_ABCD, 1'b0}); end
    endtask

    initial begin
        test_reset();
        test_ifu_read();
        test_lsu_store();
        test_store_w_first();
        test_lsu_load_err();
        test_simultaneous();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
